// File: rtl/pipe_add_sub_pkg.sv
//============================================================================
// Module   : pipe_add_sub_pkg
// Purpose  : Op encodings and slice-size helper for the pipelined add/sub unit.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package pipe_add_sub_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_add_sub_cla_group.sv
//============================================================================
// Module   : cla_group
// Purpose  : CHUNK-bit carry-lookahead group with group propagate/generate.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module cla_group #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             p_grp,
  output logic             g_grp
);

  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK:0]   w_c;
  logic             w_gg;

  assign w_p = a ^ b;
  assign w_g = a & b;

  always_comb begin
    w_c[0] = cin;
    w_gg   = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      w_gg     = w_g[i] | (w_p[i] & w_gg);
    end
  end

  assign sum   = w_p ^ w_c[CHUNK-1:0];
  assign cout  = w_c[CHUNK];
  assign p_grp = &w_p;
  assign g_grp = w_gg;

endmodule

`default_nettype wire

// File: rtl/pipe_add_sub.sv
//============================================================================
// Module   : pipe_add_sub
// Purpose  : Pipelined WIDTH-bit ADD/SUB/ADC/SBB with carry, overflow and
//            zero flags; one carry slice per stage, valid/ready both sides.
//            Optional saturation enabled by macro PIPE_ADD_SUB_SAT_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pipe_add_sub
  import pipe_add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CHUNK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
`ifdef PIPE_ADD_SUB_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int c_slice = slice_width(WIDTH, STAGES);
  localparam int c_ngrp  = c_slice / CHUNK;

  if ((STAGES < 1) || (CHUNK < 1) || (WIDTH % STAGES != 0) ||
      (c_slice % CHUNK != 0) || (STAGES > WIDTH / CHUNK)) begin : g_param_check
    $error("pipe_add_sub: illegal WIDTH/STAGES/CHUNK combination");
  end

  logic [STAGES-1:0][WIDTH-1:0] r_a, r_b, r_sum;
  logic [STAGES-1:0]            r_c, r_vld;
  logic                         r_ovf, r_zero;

  logic [STAGES-1:0][WIDTH-1:0] w_a_in, w_b_in, w_sum_in, w_sum_nxt;
  logic [STAGES-1:0]            w_c_in, w_c_nxt, w_vld_in;
  logic                         w_ovf, w_zero, w_adv;
  logic [WIDTH-1:0]             w_bp;
  logic                         w_c0;
`ifdef PIPE_ADD_SUB_SAT_EN
  logic [STAGES-1:0]            r_sat, w_sat_in;
  logic w_unused_tail;
  assign w_unused_tail = ^{r_a[STAGES-1], r_b[STAGES-1], r_sat[STAGES-1]};
`else
  logic w_unused_tail;
  assign w_unused_tail = ^{r_a[STAGES-1], r_b[STAGES-1]};
`endif

  // The whole pipe moves together; only a stalled valid output blocks it.
  assign w_adv    = !r_vld[STAGES-1] || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_bp = in_b;
    w_c0 = 1'b0;
    case (in_op)
      OP_SUB: begin w_bp = ~in_b; w_c0 = 1'b1;   end
      OP_ADC: begin               w_c0 = in_cin; end
      OP_SBB: begin w_bp = ~in_b; w_c0 = in_cin; end
      default: ;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [c_ngrp:0]    w_gc;
    logic [c_slice-1:0] w_ssum;
    logic [WIDTH-1:0]   w_raw;
    logic [c_ngrp-1:0]  w_unused_p, w_unused_g;

    if (k == 0) begin : g_first
      assign w_a_in[k]   = in_a;
      assign w_b_in[k]   = w_bp;
      assign w_c_in[k]   = w_c0;
      assign w_sum_in[k] = '0;
      assign w_vld_in[k] = in_valid;
`ifdef PIPE_ADD_SUB_SAT_EN
      assign w_sat_in[k] = in_sat;
`endif
    end else begin : g_follow
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_c_in[k]   = r_c[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_vld_in[k] = r_vld[k-1];
`ifdef PIPE_ADD_SUB_SAT_EN
      assign w_sat_in[k] = r_sat[k-1];
`endif
    end

    assign w_gc[0] = w_c_in[k];
    for (genvar j = 0; j < c_ngrp; j++) begin : g_grp
      cla_group #(.CHUNK(CHUNK)) u_cla (
        .a     (w_a_in[k][k*c_slice + j*CHUNK +: CHUNK]),
        .b     (w_b_in[k][k*c_slice + j*CHUNK +: CHUNK]),
        .cin   (w_gc[j]),
        .sum   (w_ssum[j*CHUNK +: CHUNK]),
        .cout  (w_gc[j+1]),
        .p_grp (w_unused_p[j]),
        .g_grp (w_unused_g[j])
      );
    end

    always_comb begin
      w_raw = w_sum_in[k];
      w_raw[k*c_slice +: c_slice] = w_ssum;
    end
    assign w_c_nxt[k] = w_gc[c_ngrp];

    if (k == STAGES - 1) begin : g_last
      logic w_cmsb, w_ov;
      logic [WIDTH-1:0] w_fin;
      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
      assign w_cmsb = w_a_in[k][WIDTH-1] ^ w_b_in[k][WIDTH-1] ^ w_raw[WIDTH-1];
      assign w_ov   = w_cmsb ^ w_gc[c_ngrp];
`ifdef PIPE_ADD_SUB_SAT_EN
      // A wrapped MSB of 1 means the true result was positive.
      assign w_fin = (w_sat_in[k] && w_ov) ?
                     (w_raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}}) : w_raw;
`else
      assign w_fin = w_raw;
`endif
      assign w_sum_nxt[k] = w_fin;
      assign w_ovf        = w_ov;
      assign w_zero       = ~|w_fin;
    end else begin : g_pass
      assign w_sum_nxt[k] = w_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= '0;
      r_vld  <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
`ifdef PIPE_ADD_SUB_SAT_EN
      r_sat  <= '0;
`endif
    end else if (w_adv) begin
      r_a    <= w_a_in;
      r_b    <= w_b_in;
      r_sum  <= w_sum_nxt;
      r_c    <= w_c_nxt;
      r_vld  <= w_vld_in;
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
`ifdef PIPE_ADD_SUB_SAT_EN
      r_sat  <= w_sat_in;
`endif
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out_sum   = r_sum[STAGES-1];
  assign out_cout  = r_c[STAGES-1];
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_pipe_add_sub.sv
//============================================================================
// Module   : tb_pipe_add_sub
// Purpose  : Scoreboard bench for pipe_add_sub with directed vectors.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pipe_add_sub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int CHUNK  = 4;
  localparam int NVEC   = 18;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        cin;
    logic        sat;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_cin, in_sat;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [31:0] out_sum;

  res_t q[$];
  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pop_cnt, pop_first, pop_last, acc_cycle, first_acc, stale;
  res_t mon_got, mon_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
`ifdef PIPE_ADD_SUB_SAT_EN
    .in_sat    (in_sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] op, input logic cin, input logic sat,
                              input logic [31:0] s, input logic c, input logic v,
                              input logic z);
    vec_t t;
    t.a = a; t.b = b; t.op = op; t.cin = cin; t.sat = sat;
    t.exp.sum = s; t.exp.cout = c; t.exp.ovf = v; t.exp.zero = z;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got = {out_sum, out_cout, out_ovf, out_zero};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got sum=%h c=%b v=%b z=%b with empty scoreboard",
                 mon_got.sum, mon_got.cout, mon_got.ovf, mon_got.zero);
      end else begin
        mon_exp = q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL result got sum=%h c=%b v=%b z=%b exp sum=%h c=%b v=%b z=%b",
                   mon_got.sum, mon_got.cout, mon_got.ovf, mon_got.zero,
                   mon_exp.sum, mon_exp.cout, mon_exp.ovf, mon_exp.zero);
        end
      end
      if (pop_cnt == 0) pop_first = cyc;
      pop_last = cyc;
      pop_cnt++;
    end
  end

  task automatic send(input vec_t v);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a = v.a; in_b = v.b; in_op = v.op; in_cin = v.cin; in_sat = v.sat;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(v.exp);
        acc_cycle = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready stayed 0");
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    in_cin = 1'b0; in_sat = 1'b0; out_ready = 1'b1; pop_cnt = 0;

    //              a             b             op     cin sat  sum           c  v  z
    vecs[0]  = mk(32'hFFFFFFFF, 32'h00000001, 2'b00, 0, 0, 32'h00000000, 1, 0, 1);
    vecs[1]  = mk(32'h80000000, 32'h00000001, 2'b01, 0, 0, 32'h7FFFFFFF, 1, 1, 0);
    vecs[2]  = mk(32'h0000FFFF, 32'h00000000, 2'b10, 1, 0, 32'h00010000, 0, 0, 0);
    vecs[3]  = mk(32'h00000005, 32'h00000007, 2'b11, 1, 0, 32'hFFFFFFFE, 0, 0, 0);
    vecs[4]  = mk(32'h7FFFFFFF, 32'h00000001, 2'b00, 0, 0, 32'h80000000, 0, 1, 0);
    vecs[5]  = mk(32'h00000005, 32'h00000005, 2'b01, 0, 0, 32'h00000000, 1, 0, 1);
    vecs[6]  = mk(32'h12345678, 32'h11111111, 2'b00, 0, 0, 32'h23456789, 0, 0, 0);
    vecs[7]  = mk(32'h00000000, 32'h00000000, 2'b11, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
    vecs[8]  = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
    vecs[9]  = mk(32'h00000000, 32'h00000001, 2'b01, 0, 0, 32'hFFFFFFFF, 0, 0, 0);
    vecs[10] = mk(32'h80000000, 32'h80000000, 2'b00, 0, 0, 32'h00000000, 1, 1, 1);
    vecs[11] = mk(32'h0000000F, 32'h00000001, 2'b00, 0, 0, 32'h00000010, 0, 0, 0);
    vecs[12] = mk(32'h00FF0000, 32'h00010000, 2'b00, 0, 0, 32'h01000000, 0, 0, 0);
    vecs[13] = mk(32'h00000000, 32'h00000000, 2'b10, 0, 0, 32'h00000000, 0, 0, 1);
    vecs[14] = mk(32'h7FFFFFFF, 32'hFFFFFFFF, 2'b01, 0, 0, 32'h80000000, 0, 1, 0);
    vecs[15] = mk(32'h00000001, 32'h00000001, 2'b00, 1, 0, 32'h00000002, 0, 0, 0);
    vecs[16] = mk(32'h00000003, 32'h00000001, 2'b01, 0, 0, 32'h00000002, 1, 0, 0);
    vecs[17] = mk(32'h00000000, 32'h00000001, 2'b11, 1, 0, 32'hFFFFFFFF, 0, 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum", out_sum, 0);
    chk("reset_flags", {out_cout, out_ovf, out_zero}, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back stream of all directed vectors.
    pop_cnt = 0;
    for (int i = 0; i < NVEC; i++) begin
      send(vecs[i]);
      if (i == 0) first_acc = acc_cycle;
    end
    drain("stream_drain");
    chk("latency", pop_first - first_acc, STAGES);
    chk("consecutive", pop_last - pop_first, NVEC - 1);
    chk("stream_count", pop_cnt, NVEC);

    // Backpressure: three-cycle output stall in the middle of a stream.
    pop_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(vecs[i]);
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          if (q.size() > 0)
            chk("stall_hold", {out_sum, out_cout, out_ovf, out_zero}, q[0]);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stall_drain");
    chk("stall_count", pop_cnt, 8);

    // Reset with three operations in flight.
    for (int i = 8; i < 11; i++) send(vecs[i]);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", out_sum, 0);
    chk("async_rst_flags", {out_cout, out_ovf, out_zero}, 0);
    chk("async_rst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_result", stale, 0);
    @(posedge clk);
    #1;

    // Pipe works normally after reset recovery.
    pop_cnt = 0;
    for (int i = 11; i < 16; i++) send(vecs[i]);
    drain("post_reset_drain");
    chk("post_reset_count", pop_cnt, 5);

`ifdef PIPE_ADD_SUB_SAT_EN
    send(mk(32'h7FFFFFFF, 32'h00000001, 2'b00, 0, 1, 32'h7FFFFFFF, 0, 1, 0));
    send(mk(32'h80000000, 32'h80000000, 2'b00, 0, 1, 32'h80000000, 1, 1, 0));
    send(mk(32'h00000005, 32'h00000005, 2'b01, 0, 1, 32'h00000000, 1, 0, 1));
    drain("sat_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
